// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its sequencing FSM:
// operation encodings, default operand width and the internal mode type.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        MODE_ADD = OP_ADD,
        MODE_SUB = OP_SUB,
        MODE_MUL = OP_MUL,
        MODE_DIV = OP_DIV
    } alu_mode_e;

    // Two's-complement overflow: operands share a sign the result does not.
    function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu_step_counter.sv
// Iteration counter for the MUL/DIV loops: preset to WIDTH, decrement with
// saturation at zero, and a combinational zero flag for the FSM.
module alu_step_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             preset_i,
    input  logic             clear_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Preset wins over a same-edge clear so an FSM may load and arm the loop together.
    always_comb begin
        count_d = count_q;
        if (preset_i) begin
            count_d = CNT_W'(WIDTH);
        end else if (clear_i) begin
            count_d = '0;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/alu_datapath.sv
// ALU datapath: single-cycle ADD/SUB, Booth multiply, non-restoring divide.
// Optional ALU_DIV0_FLAG_EN adds div_by_zero and a forced divide-by-zero result.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               compute,
    input  logic               dec_count,
    input  logic               reset_count,
    input  logic [1:0]         select_op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               zero_count,
    output logic [2*WIDTH-1:0] result,
    output logic               ovf
`ifdef ALU_DIV0_FLAG_EN
    ,
    output logic               div_by_zero
`endif
);

    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q1_q, q1_d;
    logic [WIDTH-1:0] m_q, m_d;
    alu_mode_e        mode_q, mode_d;
    logic             fix_pending_q, fix_pending_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0] add_full, sub_full;
    logic [WIDTH:0] m_sext, m_zext;
    logic [WIDTH:0] booth_sum, div_shift, div_sum;
    logic           is_add_sub_load;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};
    assign m_sext   = {m_q[WIDTH-1], m_q};
    assign m_zext   = {1'b0, m_q};

    assign is_add_sub_load = load && !select_op[1];

    alu_step_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .preset_i (reset_count),
        .clear_i  (is_add_sub_load),
        .dec_i    (dec_count),
        .count_o  (count),
        .zero_o   (zero_count)
    );

    always_comb begin
        unique case ({q_q[0], q1_q})
            2'b01:   booth_sum = acc_q + m_sext;
            2'b10:   booth_sum = acc_q - m_sext;
            default: booth_sum = acc_q;
        endcase
    end

    // The sign of acc before the shift picks subtract or add; the shifted value may wrap but the sum fits.
    assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign div_sum   = acc_q[WIDTH] ? (div_shift + m_zext) : (div_shift - m_zext);

    always_comb begin
        acc_d         = acc_q;
        q_d           = q_q;
        q1_d          = q1_q;
        m_d           = m_q;
        mode_d        = mode_q;
        fix_pending_d = fix_pending_q;
        ovf_d         = ovf_q;

        if (load) begin
            mode_d        = alu_mode_e'(select_op);
            fix_pending_d = 1'b0;
            q1_d          = 1'b0;
            unique case (select_op)
                OP_ADD: begin
                    acc_d = {{WIDTH{1'b0}}, add_full[WIDTH]};
                    q_d   = add_full[WIDTH-1:0];
                    ovf_d = signed_ovf(a[WIDTH-1], b[WIDTH-1], add_full[WIDTH-1]);
                end
                OP_SUB: begin
                    acc_d = {{WIDTH{1'b0}}, sub_full[WIDTH]};
                    q_d   = sub_full[WIDTH-1:0];
                    ovf_d = signed_ovf(a[WIDTH-1], ~b[WIDTH-1], sub_full[WIDTH-1]);
                end
                OP_MUL: begin
                    acc_d = '0;
                    q_d   = a;
                    m_d   = b;
                    ovf_d = 1'b0;
                end
                default: begin
                    acc_d         = '0;
                    q_d           = a;
                    m_d           = b;
                    ovf_d         = 1'b0;
                    fix_pending_d = 1'b1;
                end
            endcase
        end else if (compute) begin
            if (count != '0) begin
                if (mode_q == MODE_MUL) begin
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                    q1_d  = q_q[0];
                end else if (mode_q == MODE_DIV) begin
                    acc_d = div_sum;
                    q_d   = {q_q[WIDTH-2:0], ~div_sum[WIDTH]};
                end
            end else if ((mode_q == MODE_DIV) && fix_pending_q) begin
                // Restore a negative final remainder once the loop has run out.
                if (acc_q[WIDTH]) begin
                    acc_d = acc_q + m_zext;
                end
                fix_pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            q_q           <= '0;
            q1_q          <= 1'b0;
            m_q           <= '0;
            mode_q        <= MODE_ADD;
            fix_pending_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            q_q           <= q_d;
            q1_q          <= q1_d;
            m_q           <= m_d;
            mode_q        <= mode_d;
            fix_pending_q <= fix_pending_d;
            ovf_q         <= ovf_d;
        end
    end

    assign ovf = ovf_q;

`ifdef ALU_DIV0_FLAG_EN
    logic             div0_q;
    logic [WIDTH-1:0] a_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div0_q <= 1'b0;
            a_q    <= '0;
        end else if (load) begin
            div0_q <= (select_op == OP_DIV) && (b == '0);
            a_q    <= a;
        end
    end

    assign div_by_zero = div0_q;
    assign result      = div0_q ? {a_q, {WIDTH{1'b1}}} : {acc_q[WIDTH-1:0], q_q};
`else
    assign result = {acc_q[WIDTH-1:0], q_q};
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: scoreboard of expected results, FSM-like
// load/compute sequencing, counter saturation and asynchronous reset checks.
module tb_alu_datapath;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        compute;
    logic        dec_count;
    logic        reset_count;
    logic [1:0]  select_op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        zero_count;
    logic [15:0] result;
    logic        ovf;
`ifdef ALU_DIV0_FLAG_EN
    logic        div_by_zero;
`endif

    alu_datapath #(.WIDTH(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .compute     (compute),
        .dec_count   (dec_count),
        .reset_count (reset_count),
        .select_op   (select_op),
        .a           (a),
        .b           (b),
        .zero_count  (zero_count),
        .result      (result),
        .ovf         (ovf)
`ifdef ALU_DIV0_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load        = 1'b0;
        compute     = 1'b0;
        dec_count   = 1'b0;
        reset_count = 1'b0;
    endtask

    // Drives one operation like the control FSM would and compares at DONE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] va,
                          input logic [7:0] vb, input logic [15:0] exp_res, input logic exp_ovf);
        exp_t e;
        int   steps;
        e.tag = tag;
        e.res = exp_res;
        e.ovf = exp_ovf;
        sb.push_back(e);

        load        = 1'b1;
        select_op   = op;
        a           = va;
        b           = vb;
        reset_count = op[1];
        cycle();
        idle();

        if (op[1]) begin
            compute   = 1'b1;
            dec_count = 1'b1;
            steps     = 0;
            while (zero_count !== 1'b1 && steps < 20) begin
                cycle();
                steps++;
            end
            check({tag, " steps"}, 32'(steps), 32'd8);
            cycle();
            idle();
        end

        e = sb.pop_front();
        check(e.tag, 32'(result), 32'(e.res));
        check({e.tag, " ovf"}, 32'(ovf), 32'(e.ovf));
        check({e.tag, " zero_count"}, 32'(zero_count), 32'd1);
    endtask

    initial begin
        idle();
        select_op = OP_ADD;
        a         = '0;
        b         = '0;
        rst_n     = 1'b0;
        #12;
        check("reset result", 32'(result), 32'h0);
        check("reset ovf", 32'(ovf), 32'h0);
        check("reset zero_count", 32'(zero_count), 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();

        run_op("add 7f+01", OP_ADD, 8'h7F, 8'h01, 16'h0080, 1'b1);
        run_op("sub 00-01", OP_SUB, 8'h00, 8'h01, 16'h01FF, 1'b0);
        run_op("add ff+01", OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b0);
        run_op("sub 80-01", OP_SUB, 8'h80, 8'h01, 16'h007F, 1'b1);
        run_op("mul -3*7", OP_MUL, 8'hFD, 8'd7, 16'hFFEB, 1'b0);
        run_op("mul 80*80", OP_MUL, 8'h80, 8'h80, 16'h4000, 1'b0);
        run_op("div 200/7", OP_DIV, 8'd200, 8'd7, {8'd4, 8'd28}, 1'b0);
        run_op("div 5/9", OP_DIV, 8'd5, 8'd9, {8'd5, 8'd0}, 1'b0);
        run_op("mul 12*-5", OP_MUL, 8'd12, 8'hFB, 16'hFFC4, 1'b0);

        reset_count = 1'b1;
        cycle();
        reset_count = 1'b0;
        check("cnt preset", 32'(u_dut.u_counter.count_q), 32'd8);
        check("cnt preset zero_count", 32'(zero_count), 32'd0);
        dec_count = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (i == 7) check("cnt after 7 dec zero_count", 32'(zero_count), 32'd0);
            if (i == 8) check("cnt after 8 dec", 32'(u_dut.u_counter.count_q), 32'd0);
            if (i == 20) begin
                check("cnt saturated", 32'(u_dut.u_counter.count_q), 32'd0);
                check("cnt saturated zero_count", 32'(zero_count), 32'd1);
            end
        end
        reset_count = 1'b1;
        cycle();
        idle();
        check("cnt preset beats dec", 32'(u_dut.u_counter.count_q), 32'd8);

        load        = 1'b1;
        select_op   = OP_MUL;
        a           = 8'd3;
        b           = 8'd5;
        reset_count = 1'b1;
        cycle();
        idle();
        compute   = 1'b1;
        dec_count = 1'b1;
        repeat (4) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("async reset result", 32'(result), 32'h0);
        check("async reset zero_count", 32'(zero_count), 32'h1);
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("add 3+4 after reset", OP_ADD, 8'd3, 8'd4, 16'h0007, 1'b0);

`ifdef ALU_DIV0_FLAG_EN
        run_op("div 2a/0", OP_DIV, 8'h2A, 8'h00, 16'h2AFF, 1'b0);
        check("div_by_zero set", 32'(div_by_zero), 32'd1);
        run_op("add clears div0", OP_ADD, 8'd1, 8'd1, 16'h0002, 1'b0);
        check("div_by_zero cleared", 32'(div_by_zero), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
